// File: rtl/queue2_pkg.sv
// Shared constants and types for the two-entry message queue.
// Message width is left to the instantiating module.
package queue2_pkg;

  localparam int QUEUE_DEPTH = 2;
  localparam int PTR_W       = 1;

  // Occupancy value that means "no free entry".
  localparam logic [1:0] CNT_FULL  = 2'(QUEUE_DEPTH);
  localparam logic [1:0] CNT_EMPTY = 2'd0;

  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/queue2_rtl_register.sv
// Parameterized enable register used as one queue entry.
// Synchronous active-high reset clears the stored value to zero.
module Register_RTL #(
  parameter int p_nbits = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [p_nbits-1:0] i_d,
  output logic [p_nbits-1:0] o_q
);

  logic [p_nbits-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/queue2_rtl.sv
// Two-entry in-order FIFO with registered valid/ready outputs.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// enq_rdy and deq_val depend only on registered state, never on the partner's signal.
module queue2_rtl
  import queue2_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic [1:0]         count
);

  ptr_t       r_head;
  ptr_t       r_tail;
  logic [1:0] r_count;

  logic               w_enq_rdy;
  logic               w_deq_val;
  logic               w_enq;
  logic               w_deq;
  logic [p_nbits-1:0] w_entry [QUEUE_DEPTH];

  always_comb begin
    w_enq_rdy = 1'b0;
    w_deq_val = 1'b0;
    w_enq_rdy = !rst && (r_count != CNT_FULL);
    w_deq_val = !rst && (r_count != CNT_EMPTY);
    w_enq     = enq_val && w_enq_rdy;
    w_deq     = deq_rdy && w_deq_val;
  end

  // Only the entry the tail points at is written on an enqueue.
  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
    Register_RTL #(
      .p_nbits (p_nbits)
    ) u_entry (
      .i_clk (clk),
      .i_rst (rst),
      .i_en  (w_enq && (r_tail == ptr_t'(gi))),
      .i_d   (enq_msg),
      .o_q   (w_entry[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_EMPTY;
    end else begin
      if (w_enq) r_tail <= r_tail + ptr_t'(1);
      if (w_deq) r_head <= r_head + ptr_t'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign enq_rdy = w_enq_rdy;
  assign deq_val = w_deq_val;
  assign deq_msg = w_entry[r_head];
  assign count   = r_count;

endmodule

// File: doc/queue2_rtl.md
QUEUE2_RTL -- requirements
Module: queue2_rtl

Interface
REQ-001 SHALL have parameter p_nbits, default 32, giving the message width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port enq_val, input, 1 bit: producer offers enq_msg this cycle.
REQ-005 SHALL have port enq_rdy, output, 1 bit: queue accepts a message this cycle.
REQ-006 SHALL have port enq_msg, input, p_nbits: message to enqueue.
REQ-007 SHALL have port deq_val, output, 1 bit: deq_msg holds a valid head entry.
REQ-008 SHALL have port deq_rdy, input, 1 bit: consumer takes the head entry this cycle.
REQ-009 SHALL have port deq_msg, output, p_nbits: current head entry.
REQ-010 SHALL have port count, output, 2 bits: number of occupied entries (0..2).

Function
REQ-011 SHALL be a 2-entry FIFO with strict in-order delivery.
REQ-012 SHALL enqueue exactly when enq_val && enq_rdy; SHALL dequeue exactly when deq_val && deq_rdy.
REQ-013 SHALL drive enq_rdy = !rst && (count != 2), from registered state only (no combinational path from deq_rdy).
REQ-014 SHALL drive deq_val = !rst && (count != 0), from registered state only (no bypass from enq_val).
REQ-015 SHALL present an enqueued message on deq_msg with deq_val=1 exactly 1 cycle after the enqueue edge.
REQ-016 SHALL hold 1-bit head and tail pointers; each SHALL advance on its own transfer and wrap 1->0.
REQ-017 SHALL drive deq_msg from the entry at the head pointer; its value is unspecified while deq_val=0.
REQ-018 SHALL update count: +1 on enqueue only, -1 on dequeue only, unchanged on both or neither.
REQ-019 SHALL, at count=1 with simultaneous enqueue and dequeue, deliver the old head, store the new message, and keep count at 1.
REQ-020 SHALL, when full (count=2), refuse enqueue even if deq_rdy=1 in the same cycle; the dequeue proceeds and enq_rdy rises next cycle.
REQ-021 SHALL, when empty, ignore deq_rdy; count SHALL never underflow or exceed 2.
REQ-022 SHALL leave enq_msg values offered while enq_rdy=0 unstored.

Reset
REQ-023 SHALL, on any edge with rst=1, set count=0, head=0 and tail=0, and zero both entries, discarding any message mid-flight.
REQ-024 SHALL, while rst=1, drive enq_rdy=0 and deq_val=0, and ignore all enqueue and dequeue requests.
REQ-025 SHALL, on the first cycle after rst falls, show enq_rdy=1, deq_val=0, count=0, deq_msg=0.

Structure
REQ-026 SHALL place the queue depth constant (2) and the pointer width (1) in the shared processor package; message width stays a module parameter.
REQ-027 SHALL instantiate each entry as the team's parameterized enable register (Register_RTL, p_nbits wide, enabled by enqueue && tail==index); this is the only sub-module.
REQ-028 SHALL keep pointers and count in always_ff with synchronous reset, and all ready/valid logic in always_comb.

Verification
REQ-029 Bench SHALL cover: reset, enq 0xA5 -> next cycle deq_val=1, deq_msg=0xA5, count=1; deq_rdy=1 -> next cycle deq_val=0, count=0.
REQ-030 Bench SHALL cover: enq 0x11, 0x22 with deq_rdy=0 -> count=2, enq_rdy=0; enq 0x33 offered is dropped; then deq yields 0x11, 0x22 in order.
REQ-031 Bench SHALL cover: full queue, enq_val=1 and deq_rdy=1 -> 0x11 out, count=1, 0x33 not taken; next cycle enq_rdy=1.
REQ-032 Bench SHALL cover: count=1 (0x44), enq 0x55 with deq_rdy=1 -> 0x44 out, count stays 1; next deq gives 0x55 (pointer wrap exercised).
REQ-033 Bench SHALL cover: count=2, assert rst for 1 cycle with enq_val=1 -> during reset enq_rdy=0, deq_val=0; after reset count=0, deq_msg=0.
REQ-034 Bench SHALL cover: 1000 cycles of random enq_val/deq_rdy -> output stream equals input order, count matches a golden model every cycle.
